qsys_system_reduzido_nios2_qsys_0_oci_dct_packer: RTL and testbench

Packs 2-bit direct-compressed-trace (DCT) atoms from the Nios II OCI trace path into 30-bit / 15-slot frames. Exposes the live accumulator as `dct_buffer`/`dct_count` for the OCI test-bench monitor. Hands completed or flushed frames to the trace FIFO over a valid/ready port. Generates the `test_ending` → `test_has_ended` end-of-trace handshake.

---
 rtl/qsys_system_reduzido_nios2_qsys_0_oci_dct_packer.sv | 107 ++++++++++
 tb/tb_qsys_system_reduzido_nios2_qsys_0_oci_dct_packer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_system_reduzido_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit DCT trace atoms into 15-slot frames and hands them to the trace FIFO.
// Also drives the live accumulator view and the end-of-trace acknowledge.
module qsys_system_reduzido_nios2_qsys_0_oci_dct_packer #(
   parameter int ATOM_W = 2,
   parameter int SLOTS  = 15,
   parameter int CNT_W  = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      atom_valid,
   input  logic [ATOM_W-1:0]         atom,
   input  logic                      flush,
   input  logic                      test_ending,
   input  logic                      frame_ready,
   output logic                      frame_valid,
   output logic [ATOM_W*SLOTS-1:0]   frame_buffer,
   output logic [CNT_W-1:0]          frame_count,
   output logic [ATOM_W*SLOTS-1:0]   dct_buffer,
   output logic [CNT_W-1:0]          dct_count,
   output logic                      overflow,
   output logic [7:0]                drop_count,
   output logic                      test_has_ended
);

   logic                      flush_pending;
   logic                      end_latched;
   logic                      test_ending_reg;

   logic                      full;
   logic                      free;
   logic                      xfer;
   logic                      take;
   logic                      accept;
   logic                      drop;
   logic                      te_rise;
   logic [CNT_W-1:0]          wr_idx;
   logic [CNT_W-1:0]          accept_cnt;
   logic [CNT_W-1:0]          count_next;
   logic [ATOM_W*SLOTS-1:0]   base_buffer;
   logic [ATOM_W*SLOTS-1:0]   buffer_next;

   assign full       = (dct_count == CNT_W'(SLOTS));
   assign free       = !frame_valid || frame_ready;
   assign xfer       = free && (full || (flush_pending && dct_count != '0));
   assign take       = atom_valid && !end_latched;
   assign accept     = take && (!full || xfer);
   assign drop       = take && full && !xfer;
   assign te_rise    = test_ending && !test_ending_reg;
   assign accept_cnt = {{(CNT_W-1){1'b0}}, accept};

   // A transferring frame leaves an empty accumulator, so a same-cycle atom lands in slot 0.
   assign base_buffer = xfer ? '0 : dct_buffer;
   assign wr_idx      = xfer ? '0 : dct_count;
   assign count_next  = xfer ? accept_cnt : dct_count + accept_cnt;

   genvar gi;
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_slot
         assign buffer_next[gi*ATOM_W +: ATOM_W] =
            (accept && wr_idx == CNT_W'(gi)) ? atom : base_buffer[gi*ATOM_W +: ATOM_W];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_valid     <= 1'b0;
         frame_buffer    <= '0;
         frame_count     <= '0;
         dct_buffer      <= '0;
         dct_count       <= '0;
         overflow        <= 1'b0;
         drop_count      <= '0;
         test_has_ended  <= 1'b0;
         flush_pending   <= 1'b0;
         end_latched     <= 1'b0;
         test_ending_reg <= 1'b0;
      end else begin
         test_ending_reg <= test_ending;
         if (te_rise)
            end_latched <= 1'b1;

         // An empty accumulator simply retires a pending flush without emitting a frame.
         flush_pending <= flush || te_rise || (flush_pending && !xfer && dct_count != '0);

         if (xfer) begin
            frame_buffer <= dct_buffer;
            frame_count  <= dct_count;
            frame_valid  <= 1'b1;
         end else if (frame_ready) begin
            frame_valid  <= 1'b0;
         end

         dct_buffer <= buffer_next;
         dct_count  <= count_next;

         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF)
               drop_count <= drop_count + 8'd1;
         end

         if (end_latched && dct_count == '0 && !flush_pending && !frame_valid)
            test_has_ended <= 1'b1;
      end
   end

endmodule

// File: tb/tb_qsys_system_reduzido_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT packer: queue-based reference model checked every cycle,
// plus literal expectations on the emitted frames and the status outputs.
module tb_qsys_system_reduzido_nios2_qsys_0_oci_dct_packer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        atom_valid;
   logic [1:0]  atom;
   logic        flush;
   logic        test_ending;
   logic        frame_ready;
   logic        frame_valid;
   logic [29:0] frame_buffer;
   logic [3:0]  frame_count;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        overflow;
   logic [7:0]  drop_count;
   logic        test_has_ended;

   int n_checks = 0;
   int n_fail   = 0;

   qsys_system_reduzido_nios2_qsys_0_oci_dct_packer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .atom_valid     (atom_valid),
      .atom           (atom),
      .flush          (flush),
      .test_ending    (test_ending),
      .frame_ready    (frame_ready),
      .frame_valid    (frame_valid),
      .frame_buffer   (frame_buffer),
      .frame_count    (frame_count),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .overflow       (overflow),
      .drop_count     (drop_count),
      .test_has_ended (test_has_ended)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the accumulator is a plain list of atoms, frames are (data,count) pairs.
   int          m_q[$];
   logic        m_fv;
   logic [29:0] m_fb;
   int          m_fc;
   logic        m_pend, m_end, m_te_prev, m_ovf, m_ended;
   int          m_drops;

   function automatic logic [29:0] pack_list(input int qq[$]);
      logic [29:0] v = '0;
      foreach (qq[k]) v = v | (30'(qq[k]) << (2 * k));
      return v;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_fv = 0; m_fb = '0; m_fc = 0; m_pend = 0; m_end = 0;
         m_te_prev = 0; m_ovf = 0; m_ended = 0; m_drops = 0;
      end else begin
         int  n;
         bit  go, rise;
         n    = m_q.size();
         go   = (!m_fv || frame_ready) && (n == 15 || (m_pend && n != 0));
         rise = test_ending && !m_te_prev;
         if (m_end && n == 0 && !m_pend && !m_fv) m_ended = 1;
         if (go) begin
            m_fb = pack_list(m_q);
            m_fc = n;
            m_fv = 1;
            m_q.delete();
         end else if (frame_ready) begin
            m_fv = 0;
         end
         if (atom_valid && !m_end) begin
            if (n < 15 || go) m_q.push_back(int'(atom));
            else begin
               m_ovf = 1;
               if (m_drops < 255) m_drops++;
            end
         end
         m_pend    = flush || rise || (m_pend && !go && n != 0);
         m_end     = m_end || rise;
         m_te_prev = test_ending;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("frame_valid", 32'(frame_valid), 32'(m_fv));
         if (m_fv) begin
            chk("frame_buffer", 32'(frame_buffer), 32'(m_fb));
            chk("frame_count", 32'(frame_count), 32'(m_fc));
         end
         chk("dct_buffer", 32'(dct_buffer), 32'(pack_list(m_q)));
         chk("dct_count", 32'(dct_count), 32'(m_q.size()));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("drop_count", 32'(drop_count), 32'(m_drops));
         chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
      end
   end

   // Frames actually handed over to the FIFO.
   logic [29:0] got_buf[$];
   int          got_cnt[$];
   always @(negedge clk) begin
      if (reset_n && frame_valid && frame_ready) begin
         got_buf.push_back(frame_buffer);
         got_cnt.push_back(int'(frame_count));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [1:0] a, input logic f);
      atom_valid = 1'b1;
      atom       = a;
      flush      = f;
      tick();
      atom_valid = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      got_buf.delete();
      got_cnt.delete();
   endtask

   task automatic check_frame(input string name, input logic [29:0] b, input int c);
      if (got_buf.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: no frame handed over, expected data %0h count %0d", name, b, c);
      end else begin
         chk({name, "_data"}, 32'(got_buf.pop_front()), 32'(b));
         chk({name, "_count"}, 32'(got_cnt.pop_front()), 32'(c));
      end
   endtask

   initial begin
      logic [29:0] exp2;
      reset_n = 1'b0; atom_valid = 1'b0; atom = 2'b00; flush = 1'b0;
      test_ending = 1'b0; frame_ready = 1'b1;
      #3;
      chk("reset_frame_valid", 32'(frame_valid), 32'd0);
      chk("reset_dct_count", 32'(dct_count), 32'd0);
      chk("reset_test_has_ended", 32'(test_has_ended), 32'd0);
      tick();
      reset_n = 1'b1;

      // 15 atoms 0,1,2,3,... with the FIFO ready
      for (int i = 0; i < 15; i++) send(2'(i % 4), 1'b0);
      idle(4);
      check_frame("seq15", 30'h24E4E4E4, 15);
      chk("seq15_dct_count", 32'(dct_count), 32'd0);
      chk("seq15_overflow", 32'(overflow), 32'd0);

      // 30 back-to-back 2'b11 atoms: two full frames, no drops
      for (int i = 0; i < 30; i++) send(2'b11, 1'b0);
      idle(4);
      check_frame("ones_a", 30'h3FFFFFFF, 15);
      check_frame("ones_b", 30'h3FFFFFFF, 15);
      chk("ones_drop_count", 32'(drop_count), 32'd0);

      // FIFO stalled: frame held, accumulator fills, 31st atom dropped
      do_reset();
      frame_ready = 1'b0;
      for (int i = 0; i < 31; i++) send(2'(i % 4), 1'b0);
      idle(2);
      chk("stall_frame_valid", 32'(frame_valid), 32'd1);
      chk("stall_frame_buffer", 32'(frame_buffer), 32'h24E4E4E4);
      chk("stall_dct_count", 32'(dct_count), 32'd15);
      chk("stall_overflow", 32'(overflow), 32'd1);
      chk("stall_drop_count", 32'(drop_count), 32'd1);
      frame_ready = 1'b1;
      idle(4);
      exp2 = '0;
      for (int k = 0; k < 15; k++) exp2 = exp2 | (30'((k + 3) % 4) << (2 * k));
      check_frame("stall_a", 30'h24E4E4E4, 15);
      check_frame("stall_b", exp2, 15);

      // Partial frame by flush; slot k sits in bits [2k+1:2k], so five 2'b10 give 10_1010_1010
      do_reset();
      for (int i = 0; i < 5; i++) send(2'b10, 1'b0);
      flush = 1'b1; tick(); flush = 1'b0;
      idle(4);
      check_frame("flush5", 30'h000002AA, 5);
      flush = 1'b1; tick(); flush = 1'b0;
      idle(4);
      chk("flush_empty_frames", 32'(got_buf.size()), 32'd0);

      // Flush together with the 3rd atom includes that atom
      send(2'b01, 1'b0);
      send(2'b10, 1'b0);
      send(2'b11, 1'b1);
      idle(4);
      check_frame("flush3", 30'h00000039, 3);

      // End of trace: pending atoms flushed, then acknowledge, later atoms ignored
      do_reset();
      for (int i = 0; i < 4; i++) send(2'b01, 1'b0);
      test_ending = 1'b1;
      idle(5);
      check_frame("end4", 30'h00000055, 4);
      chk("end_has_ended", 32'(test_has_ended), 32'd1);
      for (int i = 0; i < 3; i++) send(2'b11, 1'b0);
      idle(2);
      chk("end_drop_count", 32'(drop_count), 32'd0);
      chk("end_dct_count", 32'(dct_count), 32'd0);
      test_ending = 1'b0;

      // Asynchronous reset in the middle of a frame
      do_reset();
      for (int i = 0; i < 3; i++) send(2'b11, 1'b0);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_dct_count", 32'(dct_count), 32'd0);
      chk("async_dct_buffer", 32'(dct_buffer), 32'd0);
      chk("async_frame_valid", 32'(frame_valid), 32'd0);
      chk("async_frame_buffer", 32'(frame_buffer), 32'd0);
      chk("async_overflow", 32'(overflow), 32'd0);
      tick();
      reset_n = 1'b1;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
